mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous data RAM between three requesters: UART receive path (write-only), processing datapath (read/write) and UART transmit path (read-only).
- Sits between the three datapaths and the RAM.
- Eligibility follows the 2-bit phase status produced by the top-level control FSM (00 receive, 01 process, 10 transmit, 11 all done).
- Issues at most one RAM access per cycle and returns read data with a fixed latency.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- HOLD_MAX, 4, maximum consecutive grants to one requester while another eligible requester waits (overlap mode only); legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- status  in  2  phase from control FSM
- rx_req  in  1  receive-path write request
- rx_addr  in  ADDR_W  write address
- rx_wdata  in  DATA_W  write data
- rx_gnt  out  1  one-cycle pulse: rx access issued
- proc_req  in  1  processing request
- proc_we  in  1  1 = write, 0 = read
- proc_addr  in  ADDR_W  address
- proc_wdata  in  DATA_W  write data
- proc_gnt  out  1  one-cycle pulse: proc access issued
- proc_rvalid  out  1  rdata valid for proc read
- tx_req  in  1  transmit-path read request
- tx_addr  in  ADDR_W  read address
- tx_gnt  out  1  one-cycle pulse: tx access issued
- tx_rvalid  out  1  rdata valid for tx read
- rdata  out  DATA_W  read data, shared by proc and tx
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0
- busy  out  1  eligible request pending or read in flight
- viol  out  1  sticky: ineligible requester asserted req

Behaviour:
- Reset (async):
  - All outputs 0.
  - Round-robin pointer = rx.
  - Hold counter = 0.
  - In-flight read tags cleared; a read issued before reset never produces rvalid.
- Eligibility (base mode):
  - status 00: rx only.
  - status 01: proc only.
  - status 10: tx only.
  - status 11: none.
- Handshake:
  - Requester holds req/addr/wdata/we stable until its gnt pulse.
  - Sampling cycle N: winner picked from eligible asserted reqs.
  - Cycle N+1: gnt pulses; mem_en=1; mem_addr, mem_we and mem_wdata are registered copies of the winner's cycle-N inputs.
  - rx always has mem_we=1; tx always has mem_we=0.
- Back-to-back: a req held high after gnt is re-arbitrated in the gnt cycle, giving one access per cycle (throughput 1).
- Read return:
  - rvalid for the issuing requester is asserted at cycle N+2.
  - rdata = mem_rdata registered through at N+2; rdata holds its last value otherwise.
  - A 2-stage tag pipeline (none/proc/tx) steers rvalid.
- Status change:
  - Evaluated each cycle.
  - An access already registered (N+1) and its read return (N+2) complete regardless.
  - A pending req of a requester that becomes ineligible gets no gnt.
- viol:
  - Set when any req is high while that requester is ineligible for 2 consecutive cycles (a one-cycle grace absorbs phase edges).
  - Cleared only by rst.
- busy = (any eligible req) | mem_en | any in-flight read tag.
- No eligible req: mem_en=0; mem_addr, mem_we and mem_wdata hold their last values.

Optional Feature:
- Macro: ARB_OVERLAP_EN
- Defined:
  - status 01 eligible set = {rx, proc}; status 10 eligible set = {proc, tx}; 00 and 11 unchanged.
  - Contention resolved round-robin: pointer advances past the winner on a switch.
  - The same requester may win consecutively while others wait only up to HOLD_MAX grants, then must yield.
  - Hold counter resets on switch or when no competitor waits.
- Undefined:
  - Single-owner eligibility as in Behaviour.
  - Pointer and hold-counter logic absent.
  - HOLD_MAX ignored.

Test Plan:
- Reset mid-read: status=01, proc read addr 0x0010, assert rst at N+1 -> proc_rvalid never asserts; all outputs 0; busy=0.
- Receive phase write: status=00, rx_req with addr 0x0005, data 0xA7 at cycle 10 -> rx_gnt, mem_en, mem_we=1, mem_addr=0x0005, mem_wdata=0xA7 at cycle 11; busy=0 at 12 once req dropped.
- Process readback: status=01, proc read 0x0005 held for 3 cycles (RAM content 0xA7) -> 3 grants on consecutive cycles; proc_rvalid at cycles +2..+4; rdata=0xA7.
- Phase gating: status=10, proc_req held for 3 cycles -> no proc_gnt; viol=1 from the 2nd cycle and sticky; tx_req at 0x0003 still granted next cycle.
- Status edge: tx read granted in the cycle status goes 10->11 -> tx_rvalid still asserted 1 cycle later; a subsequent tx_req gets no grant.
- Overlap (ARB_OVERLAP_EN, HOLD_MAX=4): status=01, rx and proc both requesting continuously -> grant order proc×4, rx×4, proc×4, … (pointer starts rx if rx wins first: rx×4, proc×4); never 5 consecutive grants to one requester.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous data RAM between three requesters:
//   rx   - UART receive path, write-only
//   proc - processing datapath, read or write
//   tx   - UART transmit path, read-only
//
// Which requesters may use the RAM follows the 2-bit phase status from the
// top-level control FSM (00 receive, 01 process, 10 transmit, 11 done).
// At most one access is issued per cycle. A request seen in cycle N is issued
// to the RAM in cycle N+1 (gnt pulse, registered mem_* outputs). Read data
// comes back with rvalid in cycle N+2.
//
// Optional feature (macro ARB_OVERLAP_EN):
//   Undefined (default): one owner per phase, no arbitration state.
//   Defined: phase 01 admits {rx, proc} and phase 10 admits {proc, tx}.
//            Contention is round-robin. One requester may be granted at most
//            HOLD_MAX times in a row while another eligible requester waits.
//
// Parameters:
//   ADDR_W   RAM address width
//   DATA_W   RAM data width
//   HOLD_MAX consecutive-grant limit under contention (1..15, overlap only)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   status[1:0]              phase from control FSM
//   rx_req/addr/wdata        receive-path write request
//   rx_gnt                   rx access issued (one-cycle pulse)
//   proc_req/we/addr/wdata   processing request (we=1 write, 0 read)
//   proc_gnt, proc_rvalid    proc access issued / proc read data valid
//   tx_req/addr              transmit-path read request
//   tx_gnt, tx_rvalid        tx access issued / tx read data valid
//   rdata                    read data shared by proc and tx
//   mem_en/we/addr/wdata     RAM command
//   mem_rdata                RAM read data, valid one cycle after a read
//   busy                     eligible request pending or access/read in flight
//   viol                     sticky: ineligible requester held req 2 cycles
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        status,
   input  logic              rx_req,
   input  logic [ADDR_W-1:0] rx_addr,
   input  logic [DATA_W-1:0] rx_wdata,
   output logic              rx_gnt,
   input  logic              proc_req,
   input  logic              proc_we,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   output logic              proc_gnt,
   output logic              proc_rvalid,
   input  logic              tx_req,
   input  logic [ADDR_W-1:0] tx_addr,
   output logic              tx_gnt,
   output logic              tx_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              viol
);

   if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_max_range
      $error("mem_arbiter: HOLD_MAX must be within 1..15");
   end

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_PROC = 2'd1,
      TAG_TX   = 2'd2
   } tag_t;

   // Requester indices; bit positions in the 3-bit request/eligibility vectors.
   localparam logic [1:0] IDX_RX   = 2'd0;
   localparam logic [1:0] IDX_PROC = 2'd1;
   localparam logic [1:0] IDX_TX   = 2'd2;

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      onehot = 3'b001 << idx;
   endfunction

   logic [2:0]        w_req;
   logic [2:0]        w_elig;
   logic [2:0]        w_req_el;
   logic [2:0]        w_inel;
   logic              w_win_vld;
   logic [1:0]        w_win_idx;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_viol_now;

   logic [2:0]        r_gnt;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   tag_t              r_tag_p1;
   tag_t              r_tag_p2;
   logic [DATA_W-1:0] r_rdata;
   logic [2:0]        r_inel;
   logic              r_viol;

   assign w_req = {tx_req, proc_req, rx_req};

   // Eligibility is decoded from the live status every cycle, so a phase
   // change blocks a pending request immediately.
   always_comb begin
      w_elig = 3'b000;
      case (status)
         2'b00: w_elig = 3'b001;
`ifdef ARB_OVERLAP_EN
         2'b01: w_elig = 3'b011;
         2'b10: w_elig = 3'b110;
`else
         2'b01: w_elig = 3'b010;
         2'b10: w_elig = 3'b100;
`endif
         default: w_elig = 3'b000;
      endcase
   end

   assign w_req_el = w_req & w_elig;
   assign w_inel   = w_req & ~w_elig;

`ifdef ARB_OVERLAP_EN
   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   function automatic logic [1:0] idx_next(input logic [1:0] idx);
      idx_next = (idx == IDX_TX) ? IDX_RX : idx + 2'd1;
   endfunction

   // First requesting index at or after ptr, wrapping rx -> proc -> tx.
   function automatic logic [1:0] rr_pick(input logic [2:0] mask,
                                          input logic [1:0] ptr);
      logic [1:0] c1;
      logic [1:0] c2;
      c1      = idx_next(ptr);
      c2      = idx_next(c1);
      rr_pick = ptr;
      if (mask[c2]) rr_pick = c2;
      if (mask[c1]) rr_pick = c1;
      if (mask[ptr]) rr_pick = ptr;
   endfunction

   logic [1:0] r_ptr;
   logic [1:0] r_last;
   logic       r_last_vld;
   logic [3:0] r_hold;
   logic       w_comp_wait;
   logic       w_keep;
   logic       w_others;

   // The last winner keeps the RAM while it still requests, unless someone
   // else is waiting and it has already used up its HOLD_MAX grants.
   always_comb begin
      w_comp_wait = r_last_vld & (|(w_req_el & ~onehot(r_last)));
      w_keep      = r_last_vld & w_req_el[r_last] &
                    (~w_comp_wait | (r_hold < HOLD_LIM));
      w_win_vld   = |w_req_el;
      w_win_idx   = w_keep ? r_last : rr_pick(w_req_el, r_ptr);
      w_others    = |(w_req_el & ~onehot(w_win_idx));
   end

   // r_hold counts grants to the current winner made while a competitor
   // waited; the grant that starts a new run counts as the first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= IDX_RX;
         r_last     <= IDX_RX;
         r_last_vld <= 1'b0;
         r_hold     <= 4'd0;
      end else if (w_win_vld) begin
         r_ptr      <= idx_next(w_win_idx);
         r_last     <= w_win_idx;
         r_last_vld <= 1'b1;
         if (!w_others)
            r_hold <= 4'd0;
         else if (r_last_vld && (w_win_idx == r_last))
            r_hold <= r_hold + 4'd1;
         else
            r_hold <= 4'd1;
      end else begin
         r_hold <= 4'd0;
      end
   end
`else
   // Exactly one requester is eligible per phase, so no arbitration state.
   always_comb begin
      w_win_vld = |w_req_el;
      w_win_idx = IDX_RX;
      if (w_req_el[IDX_PROC])
         w_win_idx = IDX_PROC;
      else if (w_req_el[IDX_TX])
         w_win_idx = IDX_TX;
   end
`endif

   // Winner's command. tx carries no write data, so mem_wdata keeps its value.
   always_comb begin
      w_sel_we    = 1'b1;
      w_sel_addr  = rx_addr;
      w_sel_wdata = rx_wdata;
      case (w_win_idx)
         IDX_PROC: begin
            w_sel_we    = proc_we;
            w_sel_addr  = proc_addr;
            w_sel_wdata = proc_wdata;
         end
         IDX_TX: begin
            w_sel_we    = 1'b0;
            w_sel_addr  = tx_addr;
            w_sel_wdata = r_mem_wdata;
         end
         default: ;
      endcase
   end

   // Stage p1: issue the access; the tag records who gets the read data.
   // Stage p2: tag lines up with mem_rdata from the RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt       <= 3'b000;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_tag_p1    <= TAG_NONE;
         r_tag_p2    <= TAG_NONE;
         r_rdata     <= '0;
         r_inel      <= 3'b000;
         r_viol      <= 1'b0;
      end else begin
         r_gnt    <= w_win_vld ? onehot(w_win_idx) : 3'b000;
         r_mem_en <= w_win_vld;
         if (w_win_vld) begin
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
         end
         if (w_win_vld && !w_sel_we)
            r_tag_p1 <= (w_win_idx == IDX_TX) ? TAG_TX : TAG_PROC;
         else
            r_tag_p1 <= TAG_NONE;
         r_tag_p2 <= r_tag_p1;
         if (r_tag_p2 != TAG_NONE)
            r_rdata <= mem_rdata;
         r_inel <= w_inel;
         if (w_viol_now)
            r_viol <= 1'b1;
      end
   end

   // An ineligible request is tolerated for one cycle so phase edges, where
   // a requester may not yet have seen the new status, do not flag.
   assign w_viol_now = |(w_inel & r_inel);

   assign rx_gnt      = r_gnt[IDX_RX];
   assign proc_gnt    = r_gnt[IDX_PROC];
   assign tx_gnt      = r_gnt[IDX_TX];
   assign mem_en      = r_mem_en;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign proc_rvalid = (r_tag_p2 == TAG_PROC);
   assign tx_rvalid   = (r_tag_p2 == TAG_TX);
   // RAM output passes straight through in the return cycle, otherwise the
   // last returned word is held.
   assign rdata       = (r_tag_p2 != TAG_NONE) ? mem_rdata : r_rdata;
   assign busy        = (|w_req_el) | r_mem_en |
                        (r_tag_p1 != TAG_NONE) | (r_tag_p2 != TAG_NONE);
   assign viol        = r_viol | w_viol_now;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  status;
   logic        rx_req;
   logic [15:0] rx_addr;
   logic [7:0]  rx_wdata;
   logic        rx_gnt;
   logic        proc_req;
   logic        proc_we;
   logic [15:0] proc_addr;
   logic [7:0]  proc_wdata;
   logic        proc_gnt;
   logic        proc_rvalid;
   logic        tx_req;
   logic [15:0] tx_addr;
   logic        tx_gnt;
   logic        tx_rvalid;
   logic [7:0]  rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        viol;

   int n_cmp;
   int n_bad;

   logic       ram_init;
   logic [7:0] ram [0:255];

   mem_arbiter #(.ADDR_W(16), .DATA_W(8), .HOLD_MAX(4)) dut (
      .clk(clk), .rst(rst), .status(status),
      .rx_req(rx_req), .rx_addr(rx_addr), .rx_wdata(rx_wdata), .rx_gnt(rx_gnt),
      .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid),
      .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt), .tx_rvalid(tx_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .viol(viol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM model: read data one cycle after mem_en.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
         ram[3]    <= 8'h5C;
         mem_rdata <= 8'h00;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ram_init = 1'b1;
      status = 2'b11;
      rx_req = 0; rx_addr = 0; rx_wdata = 0;
      proc_req = 0; proc_we = 0; proc_addr = 0; proc_wdata = 0;
      tx_req = 0; tx_addr = 0;
      repeat (2) step();
      n_cmp++; if ({rx_gnt, proc_gnt, proc_rvalid, tx_gnt, tx_rvalid, mem_en, mem_we, busy, viol} !== 9'h0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0", {rx_gnt, proc_gnt, proc_rvalid, tx_gnt, tx_rvalid, mem_en, mem_we, busy, viol}); end
      n_cmp++; if ({mem_addr, mem_wdata, rdata} !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, rdata}); end
      rst = 1'b0; ram_init = 1'b0;
   endtask

   task automatic test_rx_write;
      step();
      status = 2'b00; rx_req = 1'b1; rx_addr = 16'h0005; rx_wdata = 8'hA7;
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rxw_busy_req got %b want 1", busy); end
      step();
      rx_req = 1'b0;
      #1;
      n_cmp++; if ({rx_gnt, proc_gnt, tx_gnt, mem_en, mem_we} !== 5'b10011) begin n_bad++; $display("FAIL rxw_gnt got %b want 10011", {rx_gnt, proc_gnt, tx_gnt, mem_en, mem_we}); end
      n_cmp++; if (mem_addr !== 16'h0005) begin n_bad++; $display("FAIL rxw_addr got %h want 0005", mem_addr); end
      n_cmp++; if (mem_wdata !== 8'hA7) begin n_bad++; $display("FAIL rxw_wdata got %h want a7", mem_wdata); end
      step();
      n_cmp++; if ({rx_gnt, mem_en, busy} !== 3'b000) begin n_bad++; $display("FAIL rxw_idle got %b want 000", {rx_gnt, mem_en, busy}); end
      n_cmp++; if (mem_addr !== 16'h0005) begin n_bad++; $display("FAIL rxw_addr_hold got %h want 0005", mem_addr); end
   endtask

   task automatic test_proc_readback;
      step();
      status = 2'b01; proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0005;
      step();
      n_cmp++; if ({proc_gnt, mem_en, mem_we, proc_rvalid} !== 4'b1100) begin n_bad++; $display("FAIL rb_issue got %b want 1100", {proc_gnt, mem_en, mem_we, proc_rvalid}); end
      n_cmp++; if (mem_addr !== 16'h0005) begin n_bad++; $display("FAIL rb_addr got %h want 0005", mem_addr); end
      step();
      n_cmp++; if ({proc_gnt, proc_rvalid, tx_rvalid} !== 3'b110) begin n_bad++; $display("FAIL rb_c2 got %b want 110", {proc_gnt, proc_rvalid, tx_rvalid}); end
      n_cmp++; if (rdata !== 8'hA7) begin n_bad++; $display("FAIL rb_rdata got %h want a7", rdata); end
      step();
      proc_req = 1'b0;
      #1;
      n_cmp++; if ({proc_gnt, proc_rvalid} !== 2'b11) begin n_bad++; $display("FAIL rb_c3 got %b want 11", {proc_gnt, proc_rvalid}); end
      step();
      n_cmp++; if ({proc_gnt, proc_rvalid} !== 2'b01) begin n_bad++; $display("FAIL rb_c4 got %b want 01", {proc_gnt, proc_rvalid}); end
      step();
      n_cmp++; if ({proc_rvalid, busy} !== 2'b00) begin n_bad++; $display("FAIL rb_c5 got %b want 00", {proc_rvalid, busy}); end
      n_cmp++; if (rdata !== 8'hA7) begin n_bad++; $display("FAIL rb_rdata_hold got %h want a7", rdata); end
      // proc write: no rvalid afterwards
      proc_req = 1'b1; proc_we = 1'b1; proc_addr = 16'h0010; proc_wdata = 8'h3C;
      step();
      proc_req = 1'b0;
      #1;
      n_cmp++; if ({proc_gnt, mem_en, mem_we} !== 3'b111) begin n_bad++; $display("FAIL pw_issue got %b want 111", {proc_gnt, mem_en, mem_we}); end
      n_cmp++; if ({mem_addr, mem_wdata} !== 24'h00103C) begin n_bad++; $display("FAIL pw_cmd got %h want 00103c", {mem_addr, mem_wdata}); end
      step();
      n_cmp++; if ({proc_rvalid, proc_gnt} !== 2'b00) begin n_bad++; $display("FAIL pw_norv got %b want 00", {proc_rvalid, proc_gnt}); end
   endtask

   task automatic test_phase_gating;
      step();
      status = 2'b10;
`ifdef ARB_OVERLAP_EN
      rx_req = 1'b1; rx_addr = 16'h0007;
`else
      proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0007;
`endif
      #1;
      n_cmp++; if ({busy, viol} !== 2'b00) begin n_bad++; $display("FAIL gate_c1 got %b want 00", {busy, viol}); end
      step();
      n_cmp++; if ({rx_gnt, proc_gnt, viol} !== 3'b001) begin n_bad++; $display("FAIL gate_c2 got %b want 001", {rx_gnt, proc_gnt, viol}); end
      step();
      tx_req = 1'b1; tx_addr = 16'h0003;
      #1;
      n_cmp++; if ({rx_gnt, proc_gnt, viol} !== 3'b001) begin n_bad++; $display("FAIL gate_c3 got %b want 001", {rx_gnt, proc_gnt, viol}); end
      step();
      rx_req = 1'b0; proc_req = 1'b0; tx_req = 1'b0;
      #1;
      n_cmp++; if ({tx_gnt, rx_gnt, proc_gnt, mem_we} !== 4'b1000) begin n_bad++; $display("FAIL gate_tx got %b want 1000", {tx_gnt, rx_gnt, proc_gnt, mem_we}); end
      n_cmp++; if (mem_addr !== 16'h0003) begin n_bad++; $display("FAIL gate_tx_addr got %h want 0003", mem_addr); end
      step();
      n_cmp++; if ({tx_rvalid, proc_rvalid, viol} !== 3'b101) begin n_bad++; $display("FAIL gate_rv got %b want 101", {tx_rvalid, proc_rvalid, viol}); end
      n_cmp++; if (rdata !== 8'h5C) begin n_bad++; $display("FAIL gate_rdata got %h want 5c", rdata); end
   endtask

   task automatic test_status_edge;
      step();
      tx_req = 1'b1; tx_addr = 16'h0005;
      step();
      tx_req = 1'b0; status = 2'b11;
      #1;
      n_cmp++; if (tx_gnt !== 1'b1) begin n_bad++; $display("FAIL edge_gnt got %b want 1", tx_gnt); end
      step();
      n_cmp++; if ({tx_rvalid, busy} !== 2'b11) begin n_bad++; $display("FAIL edge_rv got %b want 11", {tx_rvalid, busy}); end
      n_cmp++; if (rdata !== 8'hA7) begin n_bad++; $display("FAIL edge_rdata got %h want a7", rdata); end
      tx_req = 1'b1;
      step();
      tx_req = 1'b0;
      #1;
      n_cmp++; if ({tx_gnt, mem_en, tx_rvalid, busy} !== 4'b0000) begin n_bad++; $display("FAIL edge_block got %b want 0000", {tx_gnt, mem_en, tx_rvalid, busy}); end
   endtask

   task automatic test_reset_mid_read;
      step();
      status = 2'b01; proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0010;
      step();
      proc_req = 1'b0;
      #1;
      n_cmp++; if (proc_gnt !== 1'b1) begin n_bad++; $display("FAIL rmr_gnt got %b want 1", proc_gnt); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({rx_gnt, proc_gnt, proc_rvalid, tx_gnt, tx_rvalid, mem_en, mem_we, busy, viol} !== 9'h0) begin n_bad++; $display("FAIL rmr_ctrl got %b want 0", {rx_gnt, proc_gnt, proc_rvalid, tx_gnt, tx_rvalid, mem_en, mem_we, busy, viol}); end
      n_cmp++; if ({mem_addr, mem_wdata, rdata} !== 32'h0) begin n_bad++; $display("FAIL rmr_data got %h want 0", {mem_addr, mem_wdata, rdata}); end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++; if ({proc_rvalid, tx_rvalid, busy} !== 3'b000) begin n_bad++; $display("FAIL rmr_norv%0d got %b want 000", k, {proc_rvalid, tx_rvalid, busy}); end
      end
   endtask

`ifdef ARB_OVERLAP_EN
   task automatic test_overlap;
      logic exp_rx;
      step();
      status = 2'b01;
      rx_req = 1'b1; rx_addr = 16'h0030; rx_wdata = 8'h11;
      proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0005;
      for (int k = 0; k < 16; k++) begin
         step();
         if (k == 15) begin rx_req = 1'b0; proc_req = 1'b0; end
         #1;
         exp_rx = ((k / 4) % 2) == 0;
         n_cmp++; if ({rx_gnt, proc_gnt} !== {exp_rx, ~exp_rx}) begin n_bad++; $display("FAIL ovl_g%0d got %b want %b", k, {rx_gnt, proc_gnt}, {exp_rx, ~exp_rx}); end
      end
      n_cmp++; if (viol !== 1'b0) begin n_bad++; $display("FAIL ovl_viol got %b want 0", viol); end
   endtask
`else
   task automatic test_single_owner;
      step();
      status = 2'b01;
      rx_req = 1'b1; rx_addr = 16'h0030; rx_wdata = 8'h11;
      proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0005;
      #1;
      n_cmp++; if ({busy, viol} !== 2'b10) begin n_bad++; $display("FAIL own_c1 got %b want 10", {busy, viol}); end
      step();
      n_cmp++; if ({rx_gnt, proc_gnt, viol} !== 3'b011) begin n_bad++; $display("FAIL own_c2 got %b want 011", {rx_gnt, proc_gnt, viol}); end
      step();
      rx_req = 1'b0; proc_req = 1'b0;
      #1;
      n_cmp++; if ({rx_gnt, proc_gnt, mem_we, viol} !== 4'b0101) begin n_bad++; $display("FAIL own_c3 got %b want 0101", {rx_gnt, proc_gnt, mem_we, viol}); end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_rx_write();
      test_proc_readback();
      test_phase_gating();
      test_status_edge();
      test_reset_mid_read();
`ifdef ARB_OVERLAP_EN
      test_overlap();
`else
      test_single_owner();
`endif
      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
